// File: rtl/connect_four_move_if.sv
// Move request / board status bundle between the keypad FSM, the move
// controller and the board consumers (win decode, display).
interface connect_four_move_if;
  logic        new_game;
  logic        move_valid;
  logic [2:0]  move_column;
  logic        move_ready;
  logic        move_done;
  logic        illegal;
  logic        player;
  logic [41:0] player_register;
  logic [41:0] onoff_register;
  logic [2:0]  last_column;
  logic [2:0]  last_height;
  logic        game_over;
  logic        winner;
  logic        draw;

  modport master (
    output new_game, move_valid, move_column,
    input  move_ready, move_done, illegal, player, player_register,
           onoff_register, last_column, last_height, game_over, winner, draw
  );

  modport slave (
    input  new_game, move_valid, move_column,
    output move_ready, move_done, illegal, player, player_register,
           onoff_register, last_column, last_height, game_over, winner, draw
  );
endinterface

// File: rtl/connect_four_move_ctrl.sv
// Connect Four move sequencer: column request -> landing row -> board write
// -> four-direction run check through the new cell -> win/draw/illegal.
module connect_four_move_ctrl #(
  parameter int WIN_LEN = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  connect_four_move_if.slave        mif
);

  typedef enum logic [2:0] {IDLE, FIND, PLACE, CHECK, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  col_q;
  logic [2:0]  row_q;
  logic [1:0]  dir_q;
  logic [5:0]  move_cnt_q;
  logic        hit_q;
  logic [41:0] player_q;
  logic [41:0] onoff_q;
  logic        turn_q;
  logic        game_over_q;
  logic        winner_q;
  logic        draw_q;
  logic        illegal_q;
  logic [2:0]  last_col_q;
  logic [2:0]  last_h_q;

  logic        clear;
  logic        accept;
  logic        bad_col;
  logic [5:0]  find_idx;
  logic        find_empty;

  logic        run_hit;
  int          run_len;
  int          dx;
  int          dy;
  int          cc;
  int          rr;
  logic        cont;
  logic [5:0]  probe_idx;

  assign clear      = reset || mif.new_game;
  assign accept     = (state_q == IDLE) && mif.move_valid && !game_over_q;
  assign bad_col    = (mif.move_column > 3'd6);
  // row_q holds the landing row once FIND exits, so the same index serves PLACE
  assign find_idx   = 6'(col_q) * 6'd6 + 6'(row_q);
  assign find_empty = !onoff_q[find_idx];

  // Run length through the placed cell along the current direction, both ways
  always_comb begin
    dx        = 1;
    dy        = 0;
    run_len   = 1;
    cc        = 0;
    rr        = 0;
    cont      = 1'b0;
    probe_idx = 6'd0;
    case (dir_q)
      2'd0:    begin dx = 0; dy = 1;  end
      2'd1:    begin dx = 1; dy = 0;  end
      2'd2:    begin dx = 1; dy = 1;  end
      default: begin dx = 1; dy = -1; end
    endcase
    for (int s = 0; s < 2; s++) begin
      cont = 1'b1;
      for (int k = 1; k < WIN_LEN; k++) begin
        cc = int'(col_q) + ((s == 0) ? dx * k : -dx * k);
        rr = int'(row_q) + ((s == 0) ? dy * k : -dy * k);
        if (cc < 0 || cc > 6 || rr < 0 || rr > 5) begin
          cont = 1'b0;
        end else begin
          probe_idx = 6'(6 * cc + rr);
          if (!onoff_q[probe_idx] || (player_q[probe_idx] != turn_q)) cont = 1'b0;
        end
        if (cont) run_len = run_len + 1;
      end
    end
    run_hit = (run_len >= WIN_LEN);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && !bad_col) state_d = FIND;
      FIND:    if (find_empty) state_d = PLACE;
               else if (row_q == 3'd5) state_d = IDLE;
      PLACE:   state_d = CHECK;
      CHECK:   if (dir_q == 2'd3) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      col_q       <= 3'd0;
      row_q       <= 3'd0;
      dir_q       <= 2'd0;
      move_cnt_q  <= 6'd0;
      hit_q       <= 1'b0;
      player_q    <= 42'd0;
      onoff_q     <= 42'd0;
      turn_q      <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
      draw_q      <= 1'b0;
      illegal_q   <= 1'b0;
      last_col_q  <= 3'd0;
      last_h_q    <= 3'd0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (bad_col) begin
              illegal_q <= 1'b1;
            end else begin
              col_q <= mif.move_column;
              row_q <= 3'd0;
            end
          end
        end
        FIND: begin
          if (!find_empty) begin
            if (row_q == 3'd5) illegal_q <= 1'b1;
            else               row_q     <= row_q + 3'd1;
          end
        end
        PLACE: begin
          onoff_q[find_idx]  <= 1'b1;
          player_q[find_idx] <= turn_q;
          last_col_q         <= col_q;
          last_h_q           <= row_q;
          move_cnt_q         <= move_cnt_q + 6'd1;
          dir_q              <= 2'd0;
          hit_q              <= 1'b0;
        end
        CHECK: begin
          if (run_hit) hit_q <= 1'b1;
          dir_q <= dir_q + 2'd1;
        end
        DONE: begin
          // a win on the last empty cell is reported as a win, not a draw
          if (hit_q) begin
            game_over_q <= 1'b1;
            winner_q    <= turn_q;
          end else if (move_cnt_q == 6'd42) begin
            game_over_q <= 1'b1;
            draw_q      <= 1'b1;
          end else begin
            turn_q <= ~turn_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign mif.move_ready      = (state_q == IDLE) && !game_over_q;
  assign mif.move_done       = (state_q == DONE);
  assign mif.illegal         = illegal_q;
  assign mif.player          = turn_q;
  assign mif.player_register = player_q;
  assign mif.onoff_register  = onoff_q;
  assign mif.last_column     = last_col_q;
  assign mif.last_height     = last_h_q;
  assign mif.game_over       = game_over_q;
  assign mif.winner          = winner_q;
  assign mif.draw            = draw_q;

endmodule

// File: tb/tb_connect_four_move_ctrl.sv
// Directed bench for connect_four_move_ctrl: timing, wins in each direction,
// illegal moves, a full-board draw and mid-move abort.
module tb_connect_four_move_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;
  localparam logic [41:0] ONE42 = 42'd1;

  always #5 clk = ~clk;

  connect_four_move_if mif();
  connect_four_move_ctrl #(.WIN_LEN(4)) dut (.clk(clk), .reset(reset), .mif(mif));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  // Issue one request at the next edge; lat = cycles from accept to done/illegal.
  task automatic do_move(input logic [2:0] col, output int lat, output logic ill,
                         output logic [41:0] s2, output logic [41:0] s3);
    int waitc;
    waitc = 0;
    lat = -1; ill = 1'b0; s2 = '0; s3 = '0;
    while (!mif.move_ready && waitc < 50) begin @(posedge clk); #1; waitc++; end
    if (!mif.move_ready) return;
    mif.move_valid = 1'b1;
    mif.move_column = col;
    @(posedge clk); #1;
    mif.move_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 2) s2 = mif.onoff_register;
      if (k == 3) s3 = mif.onoff_register;
      if (mif.move_done || mif.illegal) begin lat = k; ill = mif.illegal; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic new_game_pulse();
    mif.new_game = 1'b1;
    @(posedge clk); #1;
    mif.new_game = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mif.new_game = 1'b0; mif.move_valid = 1'b0; mif.move_column = 3'd0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    tests_run++; if (mif.move_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", mif.move_ready); end
    tests_run++; if (mif.onoff_register !== 42'd0 || mif.player_register !== 42'd0) begin tests_failed++; $display("FAIL reset_boards: onoff %h owner %h want 0", mif.onoff_register, mif.player_register); end
    tests_run++; if ({mif.player, mif.game_over, mif.winner, mif.draw, mif.move_done, mif.illegal} !== 6'b0) begin tests_failed++; $display("FAIL reset_status: got %b want 000000", {mif.player, mif.game_over, mif.winner, mif.draw, mif.move_done, mif.illegal}); end
    tests_run++; if (mif.last_column !== 3'd0 || mif.last_height !== 3'd0) begin tests_failed++; $display("FAIL reset_last: col %0d h %0d want 0/0", mif.last_column, mif.last_height); end
  endtask

  task automatic test_first_move();
    int lat; logic ill; logic [41:0] s2, s3;
    do_move(3'd3, lat, ill, s2, s3);
    tests_run++; if (lat !== 7 || ill !== 1'b0) begin tests_failed++; $display("FAIL first_latency: got %0d illegal %b want 7/0", lat, ill); end
    tests_run++; if (s2 !== 42'd0 || s3 !== (ONE42 << 18)) begin tests_failed++; $display("FAIL first_board_timing: T+2 %h T+3 %h want 0 / %h", s2, s3, ONE42 << 18); end
    tests_run++; if (mif.onoff_register !== (ONE42 << 18) || mif.player_register !== 42'd0) begin tests_failed++; $display("FAIL first_boards: onoff %h owner %h want %h / 0", mif.onoff_register, mif.player_register, ONE42 << 18); end
    tests_run++; if (mif.player !== 1'b1 || mif.last_height !== 3'd0 || mif.last_column !== 3'd3) begin tests_failed++; $display("FAIL first_status: player %b h %0d col %0d want 1/0/3", mif.player, mif.last_height, mif.last_column); end
  endtask

  task automatic test_vertical_win();
    int cols[7] = '{0, 1, 0, 1, 0, 1, 0};
    int h[7];
    int lat; logic ill; logic [41:0] s2, s3;
    logic quiet;
    new_game_pulse();
    foreach (h[i]) h[i] = 0;
    for (int i = 0; i < 7; i++) begin
      do_move(3'(cols[i]), lat, ill, s2, s3);
      tests_run++; if (lat !== h[cols[i]] + 7 || ill !== 1'b0) begin tests_failed++; $display("FAIL vert_move%0d: latency %0d illegal %b want %0d/0", i, lat, ill, h[cols[i]] + 7); end
      h[cols[i]]++;
    end
    tests_run++; if ({mif.game_over, mif.winner, mif.draw, mif.move_ready, mif.player} !== 5'b10000) begin tests_failed++; $display("FAIL vert_result: over/win/draw/ready/player %b want 10000", {mif.game_over, mif.winner, mif.draw, mif.move_ready, mif.player}); end
    mif.move_valid = 1'b1; mif.move_column = 3'd5; quiet = 1'b1;
    for (int k = 0; k < 12; k++) begin @(posedge clk); #1; if (mif.move_done || mif.illegal) quiet = 1'b0; end
    mif.move_valid = 1'b0;
    tests_run++; if (quiet !== 1'b1 || mif.onoff_register !== 42'h1CF || mif.player_register !== 42'h1C0) begin tests_failed++; $display("FAIL vert_ignored: quiet %b onoff %h owner %h want 1/1cf/1c0", quiet, mif.onoff_register, mif.player_register); end
  endtask

  task automatic test_column_full();
    int lat; logic ill; logic [41:0] s2, s3;
    new_game_pulse();
    tests_run++; if (mif.game_over !== 1'b0 || mif.move_ready !== 1'b1 || mif.onoff_register !== 42'd0) begin tests_failed++; $display("FAIL newgame_clear: over %b ready %b onoff %h want 0/1/0", mif.game_over, mif.move_ready, mif.onoff_register); end
    for (int i = 0; i < 6; i++) begin
      do_move(3'd2, lat, ill, s2, s3);
      tests_run++; if (lat !== i + 7 || ill !== 1'b0) begin tests_failed++; $display("FAIL fill_move%0d: latency %0d illegal %b want %0d/0", i, lat, ill, i + 7); end
    end
    do_move(3'd2, lat, ill, s2, s3);
    tests_run++; if (lat !== 7 || ill !== 1'b1) begin tests_failed++; $display("FAIL full_illegal: latency %0d illegal %b want 7/1", lat, ill); end
    tests_run++; if (mif.illegal !== 1'b0) begin tests_failed++; $display("FAIL illegal_pulse_width: got %b want 0", mif.illegal); end
    tests_run++; if (mif.onoff_register !== 42'h3F000 || mif.player_register !== 42'h2A000 || mif.player !== 1'b0) begin tests_failed++; $display("FAIL full_unchanged: onoff %h owner %h player %b want 3f000/2a000/0", mif.onoff_register, mif.player_register, mif.player); end
    do_move(3'd7, lat, ill, s2, s3);
    tests_run++; if (lat !== 1 || ill !== 1'b1) begin tests_failed++; $display("FAIL col7_illegal: latency %0d illegal %b want 1/1", lat, ill); end
    do_move(3'd3, lat, ill, s2, s3);
    tests_run++; if (lat !== 7 || mif.player_register !== 42'h2A000 || mif.onoff_register !== 42'h7F000 || mif.player !== 1'b1) begin tests_failed++; $display("FAIL after_illegal_move: latency %0d owner %h onoff %h player %b want 7/2a000/7f000/1", lat, mif.player_register, mif.onoff_register, mif.player); end
  endtask

  task automatic test_diagonal();
    int cols[10] = '{2, 1, 3, 2, 3, 3, 4, 4, 4, 4};
    int h[7];
    int lat; logic ill; logic [41:0] s2, s3;
    logic early;
    new_game_pulse();
    foreach (h[i]) h[i] = 0;
    early = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_move(3'(cols[i]), lat, ill, s2, s3);
      tests_run++; if (lat !== h[cols[i]] + 7) begin tests_failed++; $display("FAIL diag_move%0d: latency %0d want %0d", i, lat, h[cols[i]] + 7); end
      h[cols[i]]++;
      if (i < 9 && mif.game_over) early = 1'b1;
    end
    tests_run++; if (early !== 1'b0 || {mif.game_over, mif.winner, mif.draw, mif.player} !== 4'b1101) begin tests_failed++; $display("FAIL diag_result: early %b over/win/draw/player %b want 0 / 1101", early, {mif.game_over, mif.winner, mif.draw, mif.player}); end
  endtask

  task automatic test_horizontal_edge();
    int wrap[7] = '{5, 5, 6, 6, 0, 0, 1};
    int row0[7] = '{3, 3, 4, 4, 5, 5, 6};
    int lat; logic ill; logic [41:0] s2, s3;
    new_game_pulse();
    for (int i = 0; i < 7; i++) do_move(3'(wrap[i]), lat, ill, s2, s3);
    tests_run++; if (lat !== 7 || mif.game_over !== 1'b0 || mif.player !== 1'b1) begin tests_failed++; $display("FAIL no_wrap: latency %0d over %b player %b want 7/0/1", lat, mif.game_over, mif.player); end
    new_game_pulse();
    for (int i = 0; i < 7; i++) do_move(3'(row0[i]), lat, ill, s2, s3);
    tests_run++; if (lat !== 7 || {mif.game_over, mif.winner, mif.draw, mif.last_column} !== {3'b100, 3'd6}) begin tests_failed++; $display("FAIL horiz_win: latency %0d over/win/draw %b col %0d want 7 / 100 / 6", lat, {mif.game_over, mif.winner, mif.draw}, mif.last_column); end
  endtask

  task automatic test_draw();
    int order[42];
    int pa[3] = '{0, 1, 4};
    int pb[3] = '{2, 3, 6};
    int pat[12] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0};
    int h[7];
    int n, c, idx, lat;
    logic ill; logic [41:0] s2, s3;
    logic [41:0] exp_on, exp_own;
    n = 0;
    for (int p = 0; p < 3; p++)
      for (int j = 0; j < 12; j++) begin order[n] = (pat[j] == 1) ? pb[p] : pa[p]; n++; end
    for (int j = 0; j < 6; j++) begin order[n] = 5; n++; end
    new_game_pulse();
    foreach (h[i]) h[i] = 0;
    exp_on = '0; exp_own = '0;
    for (int i = 0; i < 42; i++) begin
      c = order[i];
      idx = 6 * c + h[c];
      do_move(3'(c), lat, ill, s2, s3);
      tests_run++; if (lat !== h[c] + 7 || (i < 41 && mif.game_over !== 1'b0)) begin tests_failed++; $display("FAIL draw_move%0d: latency %0d over %b want %0d/0", i, lat, mif.game_over, h[c] + 7); end
      exp_on = exp_on | (ONE42 << idx);
      if ((i % 2) == 1) exp_own = exp_own | (ONE42 << idx);
      h[c]++;
    end
    tests_run++; if ({mif.game_over, mif.draw, mif.move_ready, mif.player} !== 4'b1101) begin tests_failed++; $display("FAIL draw_result: over/draw/ready/player %b want 1101", {mif.game_over, mif.draw, mif.move_ready, mif.player}); end
    tests_run++; if (mif.onoff_register !== exp_on || mif.player_register !== exp_own) begin tests_failed++; $display("FAIL draw_boards: onoff %h owner %h want %h / %h", mif.onoff_register, mif.player_register, exp_on, exp_own); end
  endtask

  task automatic test_abort(input logic use_reset);
    int lat; logic ill; logic [41:0] s2, s3;
    logic quiet;
    new_game_pulse();
    do_move(3'd3, lat, ill, s2, s3);
    mif.move_valid = 1'b1; mif.move_column = 3'd4;
    @(posedge clk); #1;
    mif.move_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    tests_run++; if (mif.onoff_register[24] !== 1'b1 || mif.move_ready !== 1'b0) begin tests_failed++; $display("FAIL abort_pre_%0d: cell24 %b ready %b want 1/0", use_reset, mif.onoff_register[24], mif.move_ready); end
    if (use_reset) reset = 1'b1; else mif.new_game = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mif.new_game = 1'b0;
    tests_run++; if (mif.move_ready !== 1'b1 || mif.onoff_register !== 42'd0 || mif.player_register !== 42'd0 || mif.player !== 1'b0 || mif.move_done !== 1'b0) begin tests_failed++; $display("FAIL abort_clear_%0d: ready %b onoff %h owner %h player %b done %b want 1/0/0/0/0", use_reset, mif.move_ready, mif.onoff_register, mif.player_register, mif.player, mif.move_done); end
    quiet = 1'b1;
    for (int k = 0; k < 8; k++) begin @(posedge clk); #1; if (mif.move_done || mif.illegal) quiet = 1'b0; end
    tests_run++; if (quiet !== 1'b1 || mif.last_column !== 3'd0) begin tests_failed++; $display("FAIL abort_quiet_%0d: quiet %b last_col %0d want 1/0", use_reset, quiet, mif.last_column); end
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_vertical_win();
    test_column_full();
    test_diagonal();
    test_horizontal_edge();
    test_draw();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/connect_four_move_ctrl.md
Name: connect_four_move_ctrl

Overview:
Sequences one Connect Four move end to end. It accepts a column request, finds the landing row, and updates the 42-bit player and occupancy boards. It then checks the four line directions through the placed cell over successive cycles, and reports win, draw or illegal move. It owns the board registers that feed the win-decoding logic and the display, and sits between the input/keypad FSM and those consumers.

Parameters:
WIN_LEN, 4, run length that wins; supported values 3..4. Board geometry is fixed: 7 columns x 6 rows.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high; one clock; clears everything
new_game  input  1  clears boards and status; honoured in any state; priority just below reset
move_valid  input  1  move request
move_column  input  3  requested column 0..6
move_ready  output  1  high only in IDLE with game_over=0
move_done  output  1  1-cycle pulse, move committed and checked
illegal  output  1  1-cycle pulse, move rejected (column>6 or column full); boards unchanged
player  output  1  side to move (0 or 1)
player_register  output  42  owner bit per cell; valid where onoff is set
onoff_register  output  42  occupancy per cell
last_column  output  3  column of last committed move
last_height  output  3  row of last committed move
game_over  output  1  sticky until new_game/reset
winner  output  1  winning player; valid when game_over & ~draw
draw  output  1  sticky; board full with no win

Behaviour:
- Cell index = 6*column + row; row 0 is the bottom. A placed cell sets onoff[idx]=1 and player_register[idx]=player.
- Reset and new_game values: state=IDLE; both boards=0; player=0; game_over, winner, draw, move_done, illegal=0; last_column=0; last_height=0; move counter=0.
- States and transitions:
  - IDLE: accept when move_valid & move_ready at edge T.
    - If move_column>6: pulse illegal in cycle T+1, stay in IDLE.
    - Otherwise latch the column, clear the row counter r, go to FIND.
  - FIND: one row per cycle.
    - If onoff[6c+r]==0: height=r, go to PLACE.
    - Else if r==5: column is full; pulse illegal in the next cycle (in IDLE), go to IDLE.
    - Else r=r+1.
    - FIND lasts h+1 cycles, where h is the existing column height.
  - PLACE: write both boards, update last_column/last_height, increment the move counter (6-bit, 0..42). Go to CHECK with dir=0.
  - CHECK: one direction per cycle, 4 cycles.
    - dir encoding: 0 = vertical (0,+1), 1 = horizontal (+1,0), 2 = diagonal (+1,+1), 3 = anti-diagonal (+1,-1).
    - run = 1 + consecutive in-bounds, occupied cells owned by player stepping in the + direction (max WIN_LEN-1 steps), plus the same in the - direction.
    - Out-of-bounds or empty cells terminate the run; no wrap between columns.
    - Any run >= WIN_LEN sets an internal hit flag.
  - DONE: pulse move_done.
    - If hit: game_over=1, winner=player.
    - Else if move counter==42: game_over=1, draw=1.
    - Player toggles only when the game is not over. Then go to IDLE.
- Latency: with accept at edge T, move_done is high in cycle T+h+7. Boards reflect the move from cycle T+h+3.
- Requests while move_ready=0 are ignored; no queuing. move_valid is sampled only in IDLE.
- A win on the 42nd move reports winner, not draw.
- new_game or reset mid-move aborts without committing; no done or illegal pulse follows.
- player does not change on an illegal move.

Test Plan:
- Empty board, move col 3 -> move_done 7 cycles after accept; onoff bit 18=1; player_register bit 18=0; player=1; last_height=0.
- P0 plays col0 x4 interleaved with P1 col1 x3 -> after the 7th move: game_over=1, winner=0, draw=0, move_ready=0; player stays 0.
- Fill col 2 with 6 moves, then request col 2 -> illegal pulse 7 cycles after accept; boards, player and move counter unchanged. move_column=7 -> illegal the cycle after accept.
- Diagonal build giving P1 cells (1,0),(2,1),(3,2),(4,3), completed at (4,3) -> winner=1 after the anti-/diagonal CHECK. Horizontal row 0, cols 3..6 for P0 -> win detected; an edge run at col 6 does not wrap into col 0.
- Bench-model 42-move non-winning fill -> draw=1, game_over=1 after the 42nd move_done.
- Assert reset (or new_game) during CHECK -> next cycle: state IDLE, boards 0, player 0, no move_done; move_ready=1.
